// File: rtl/ntt_memory_wrapper.sv
// Memory-fed N-point NTT/INTT engine: loads N coefficients in bit-reversed order,
// runs an in-place radix-2 DIT transform one butterfly per cycle, then streams results out.
module ntt_memory_wrapper #(
    parameter int LOGN  = 3,
    parameter int LOGQ  = 5,
    parameter int W     = 2,
    parameter int W_INV = 9,
    parameter int N_INV = 15,
    localparam int AW   = (LOGN > 10) ? LOGN : 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            intt,
    output logic [AW-1:0]   read_address,
    output logic [AW-1:0]   write_address,
    output logic            wea,
    input  logic [LOGQ-1:0] data64_in,
    input  logic [LOGQ-1:0] q,
    output logic            finish,
    output logic [LOGQ-1:0] data64_out
);
    localparam int N  = 1 << LOGN;
    localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam logic [LOGN:0] CNT_ONE       = (LOGN+1)'(1);
    localparam logic [LOGN:0] CNT_N         = (LOGN+1)'(N);
    localparam logic [LOGN:0] CNT_LAST      = (LOGN+1)'(N - 1);
    localparam logic [LOGN:0] CNT_HALF_LAST = (LOGN+1)'(N / 2 - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;

    state_t          r_state;
    logic            r_intt;
    logic [LOGN:0]   r_cnt;
    logic [SW-1:0]   r_stage;
    logic [AW-1:0]   r_read_address;
    logic [AW-1:0]   r_write_address;
    logic            r_wea;
    logic            r_finish;
    logic [LOGQ-1:0] r_data_out;
    logic [LOGQ-1:0] r_buf [N];
    logic [LOGQ-1:0] r_tw  [N];

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
        return r;
    endfunction

    function automatic logic [LOGQ-1:0] mulmod(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b,
                                               input logic [LOGQ-1:0] m);
        logic [2*LOGQ-1:0] p;
        logic [2*LOGQ-1:0] r;
        p = {{LOGQ{1'b0}}, a} * {{LOGQ{1'b0}}, b};
        r = p % {{LOGQ{1'b0}}, m};
        return r[LOGQ-1:0];
    endfunction

    logic [LOGN-1:0] w_idx, w_prev, w_mask, w_j, w_ia, w_ib, w_e;
    logic [SW-1:0]   w_shamt;
    logic [LOGQ-1:0] w_root, w_a, w_b, w_t, w_add, w_sub, w_rd, w_wr_val;
    logic [LOGQ:0]   w_sum;

    // Butterfly addressing: pair (ia, ib) sits half = 2^stage apart inside groups of 2*half.
    assign w_idx   = r_cnt[LOGN-1:0];
    assign w_prev  = w_idx - LOGN'(1);
    assign w_root  = r_intt ? LOGQ'(W_INV) : LOGQ'(W);
    assign w_mask  = (LOGN'(1) << r_stage) - LOGN'(1);
    assign w_j     = w_idx & w_mask;
    assign w_ia    = ((w_idx & ~w_mask) << 1) | w_j;
    assign w_ib    = w_ia | (LOGN'(1) << r_stage);
    assign w_shamt = SW'(LOGN - 1) - r_stage;
    assign w_e     = w_j << w_shamt;

    assign w_a   = r_buf[w_ia];
    assign w_b   = r_buf[w_ib];
    assign w_t   = mulmod(w_b, r_tw[w_e], q);
    assign w_sum = {1'b0, w_a} + {1'b0, w_t};
    assign w_add = w_sum[LOGQ-1:0] - ((w_sum >= {1'b0, q}) ? q : '0);
    assign w_sub = w_a - w_t + ((w_a >= w_t) ? '0 : q);

    assign w_rd     = r_buf[w_idx];
    assign w_wr_val = r_intt ? mulmod(w_rd, LOGQ'(N_INV), q) : w_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_intt          <= 1'b0;
            r_cnt           <= '0;
            r_stage         <= '0;
            r_read_address  <= '0;
            r_write_address <= '0;
            r_wea           <= 1'b0;
            r_finish        <= 1'b0;
            r_data_out      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state        <= LOAD;
                        r_intt         <= intt;
                        r_cnt          <= '0;
                        r_read_address <= '0;
                    end
                end
                LOAD: begin
                    // Twiddle powers root^0..root^(N-1) are built as a running product while loading.
                    if (r_cnt < CNT_N)
                        r_tw[w_idx] <= (r_cnt == '0) ? LOGQ'(1) : mulmod(r_tw[w_prev], w_root, q);
                    if (r_cnt != '0)
                        r_buf[bitrev(w_prev)] <= data64_in;
                    r_read_address <= (r_cnt < CNT_LAST) ? AW'(r_cnt + CNT_ONE) : '0;
                    if (r_cnt == CNT_N) begin
                        r_state <= COMPUTE;
                        r_cnt   <= '0;
                        r_stage <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                COMPUTE: begin
                    r_buf[w_ia] <= w_add;
                    r_buf[w_ib] <= w_sub;
                    if (r_cnt == CNT_HALF_LAST) begin
                        r_cnt <= '0;
                        if (r_stage == SW'(LOGN - 1))
                            r_state <= WRITE;
                        else
                            r_stage <= r_stage + SW'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                WRITE: begin
                    // Outputs are registered, so the extra final cycle retires the last word.
                    if (r_cnt == CNT_N) begin
                        r_wea           <= 1'b0;
                        r_write_address <= '0;
                        r_data_out      <= '0;
                        r_finish        <= 1'b1;
                        r_state         <= DONE;
                    end else begin
                        r_wea           <= 1'b1;
                        r_write_address <= AW'(r_cnt);
                        r_data_out      <= w_wr_val;
                        r_cnt           <= r_cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        r_finish <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign read_address  = r_read_address;
    assign write_address = r_write_address;
    assign wea           = r_wea;
    assign finish        = r_finish;
    assign data64_out    = r_data_out;
endmodule

// File: tb/tb_ntt_memory_wrapper.sv
// Scoreboard bench for ntt_memory_wrapper: expected writes are queued per run and a
// negedge monitor pops and compares them whenever wea is high.
module tb_ntt_memory_wrapper;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          intt = 1'b0;
    logic [AW-1:0] read_address, write_address;
    logic          wea, finish;
    logic [4:0]    data64_in = '0;
    logic [4:0]    q = 5'd17;
    logic [4:0]    data64_out;
    logic [4:0]    mem_in [8];

    int vin [8];
    int vexp [8];
    int orig [8];
    int exp_addr_q [$];
    int exp_data_q [$];
    int errors = 0;
    int checks = 0;
    int ref_lat = -1;
    int mon_a, mon_d;

    ntt_memory_wrapper dut (
        .clk(clk), .rst(rst), .start(start), .intt(intt),
        .read_address(read_address), .write_address(write_address), .wea(wea),
        .data64_in(data64_in), .q(q), .finish(finish), .data64_out(data64_out)
    );

    always #5 clk = ~clk;

    // External memory: one-cycle read latency.
    always @(posedge clk) data64_in <= mem_in[read_address[2:0]];

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wea) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d with nothing expected",
                         write_address, data64_out);
            end else begin
                mon_a = exp_addr_q.pop_front();
                mon_d = exp_data_q.pop_front();
                check("write_addr", int'(write_address), mon_a);
                check("write_data", int'(data64_out), mon_d);
                $display("  write addr=%0d data=%0d (expect %0d @ %0d)",
                         write_address, data64_out, mon_d, mon_a);
            end
        end
    end

    function automatic int powmod(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % 17;
        return r;
    endfunction

    // Direct O(N^2) DFT over GF(17), used as the reference for random vectors.
    function automatic void dft_ref(input bit inv);
        for (int k = 0; k < 8; k++) begin
            int s = 0;
            for (int j = 0; j < 8; j++)
                s = (s + vin[j] * powmod(inv ? 9 : 2, (j * k) % 8)) % 17;
            vexp[k] = inv ? (s * 15) % 17 : s;
        end
    endfunction

    task automatic run_op(input string name, input logic inv, input bit early_drop);
        int lat = 0;
        bit seen = 0;
        for (int i = 0; i < 8; i++) begin
            mem_in[i] = 5'(vin[i]);
            exp_addr_q.push_back(i);
            exp_data_q.push_back(vexp[i]);
        end
        @(negedge clk);
        intt  = inv;
        start = 1'b1;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 2) intt = ~inv;
            if (early_drop && lat == 3) start = 1'b0;
            if (finish) seen = 1;
        end
        check({name, " finish_seen"}, seen, 1);
        check({name, " latency_bound"}, int'(lat <= 32), 1);
        if (ref_lat < 0) ref_lat = lat;
        else check({name, " latency_equal"}, lat, ref_lat);
        check({name, " all_writes"}, exp_data_q.size(), 0);
        check({name, " wea_in_done"}, wea, 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        if (!early_drop) begin
            repeat (2) @(negedge clk);
            check({name, " finish_held"}, finish, 1);
            start = 1'b0;
        end
        @(negedge clk);
        check({name, " finish_fall"}, finish, 0);
        intt = 1'b0;
        $display("run %s intt=%0d latency=%0d", name, inv, lat);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem_in[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset finish", finish, 0);
        check("reset wea", wea, 0);
        check("reset read_address", int'(read_address), 0);
        check("reset write_address", int'(write_address), 0);
        check("reset data64_out", int'(data64_out), 0);

        vin = '{1, 0, 0, 0, 0, 0, 0, 0}; vexp = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_op("fwd_delta", 1'b0, 1'b0);
        vin = '{1, 1, 1, 1, 1, 1, 1, 1}; vexp = '{8, 0, 0, 0, 0, 0, 0, 0};
        run_op("fwd_ones_early_drop", 1'b0, 1'b1);
        vin = '{8, 0, 0, 0, 0, 0, 0, 0}; vexp = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_op("inv_delta8", 1'b1, 1'b0);
        vin = '{1, 1, 1, 1, 1, 1, 1, 1}; vexp = '{1, 0, 0, 0, 0, 0, 0, 0};
        run_op("inv_ones", 1'b1, 1'b0);
        vin = '{3, 1, 4, 1, 5, 9, 2, 6}; vexp = '{14, 1, 14, 1, 14, 11, 7, 13};
        run_op("fwd_mixed", 1'b0, 1'b0);
        vin = '{14, 1, 14, 1, 14, 11, 7, 13}; vexp = '{3, 1, 4, 1, 5, 9, 2, 6};
        run_op("inv_mixed", 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) orig[i] = int'($urandom_range(0, 16));
        vin = orig;
        dft_ref(1'b0);
        run_op("fwd_random", 1'b0, 1'b0);
        vin  = vexp;
        vexp = orig;
        run_op("inv_random_roundtrip", 1'b1, 1'b0);

        // Abort in the middle of COMPUTE, then confirm a clean rerun.
        vin = '{5, 5, 5, 5, 5, 5, 5, 5};
        for (int i = 0; i < 8; i++) mem_in[i] = 5'(vin[i]);
        @(negedge clk);
        start = 1'b1;
        repeat (14) @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("midrst wea", wea, 0);
        check("midrst finish", finish, 0);
        check("midrst read_address", int'(read_address), 0);
        check("midrst data64_out", int'(data64_out), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("after_rst idle finish", finish, 0);
        $display("run mid_compute_reset done");

        vin = '{1, 0, 0, 0, 0, 0, 0, 0}; vexp = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_op("fwd_after_reset", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
